// File: rtl/param_queue_pkg.sv
// Shared definitions for the param_queue family: default widths and pointer-compare helpers.
package param_queue_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 4;

  typedef enum logic [1:0] {
    PtrPartial,
    PtrEmpty,
    PtrFull
  } ptr_rel_e;

  // Wrap-bit pointer relation: equal low bits with equal MSB is empty, differing MSB is full.
  function automatic ptr_rel_e ptr_rel(input logic low_eq, input logic wrap_eq);
    if (!low_eq) begin
      return PtrPartial;
    end
    return wrap_eq ? PtrEmpty : PtrFull;
  endfunction

endpackage

// File: rtl/param_queue_ram.sv
// Queue storage: synchronous write port and a registered read-first read port.
module param_queue_ram #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_queue.sv
// Parametrised synchronous FIFO with occupancy count, almost flags and read-valid strobe.
// Define QUEUE_ERR_FLAGS_EN to add sticky overflow_o / underflow_o outputs.
module param_queue
  import param_queue_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              Wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              Rd_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              Rd_valid_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
`ifdef QUEUE_ERR_FLAGS_EN
  output logic              overflow_o,
  output logic              underflow_o,
`endif
  output logic              almost_full_o
);

  localparam logic [ADDR_W:0] AfullTh  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AemptyTh = AEMPTY_TH[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            empty_q, full_q, aempty_q, afull_q, rd_valid_q;
  logic            push, pop, ram_we;
  ptr_rel_e        rel;

  always_comb begin
    push     = Wr_en_i && !full_q;
    pop      = Rd_en_i && !empty_q;
    ram_we   = push && Rst_i;
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
    count_d  = wr_ptr_d - rd_ptr_d;
    rel      = ptr_rel(wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0],
                       wr_ptr_d[ADDR_W] == rd_ptr_d[ADDR_W]);
  end

  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      aempty_q   <= 1'b1;
      afull_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (rel == PtrEmpty);
      full_q     <= (rel == PtrFull);
      aempty_q   <= (count_d <= AemptyTh);
      afull_q    <= (count_d >= AfullTh);
      rd_valid_q <= pop;
    end
  end

`ifdef QUEUE_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q || (Wr_en_i && full_q);
      underflow_q <= underflow_q || (Rd_en_i && empty_q);
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

  param_queue_ram #(
    .DataW (DATA_W),
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (Clk_i),
    .rst_ni  (Rst_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (data_i),
    .re_i    (pop),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (data_o)
  );

  assign Rd_valid_o     = rd_valid_q;
  assign count_o        = count_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = aempty_q;
  assign almost_full_o  = afull_q;

endmodule

// File: tb/tb_param_queue.sv
// Directed, scoreboard-checked bench for param_queue with default parameters.
module tb_param_queue;

  localparam int Depth = 16;
  localparam int AfTh  = 14;
  localparam int AeTh  = 2;

  logic       Clk_i = 1'b0;
  logic       Rst_i;
  logic       Wr_en_i;
  logic       Rd_en_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       Rd_valid_o;
  logic [4:0] count_o;
  logic       empty_o, full_o, almost_empty_o, almost_full_o;
`ifdef QUEUE_ERR_FLAGS_EN
  logic       overflow_o, underflow_o;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mdl [$];
  logic [7:0] sb  [$];
  logic [7:0] last_data;
  logic       ovf_m, unf_m;

  always #5 Clk_i = ~Clk_i;

  param_queue dut (
    .Clk_i          (Clk_i),
    .Rst_i          (Rst_i),
    .Wr_en_i        (Wr_en_i),
    .data_i         (data_i),
    .Rd_en_i        (Rd_en_i),
    .data_o         (data_o),
    .Rd_valid_o     (Rd_valid_o),
    .count_o        (count_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .almost_empty_o (almost_empty_o),
`ifdef QUEUE_ERR_FLAGS_EN
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
`endif
    .almost_full_o  (almost_full_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count_o), 32'(mdl.size()));
    chk("empty", 32'(empty_o), 32'(mdl.size() == 0));
    chk("full", 32'(full_o), 32'(mdl.size() == Depth));
    chk("almost_empty", 32'(almost_empty_o), 32'(mdl.size() <= AeTh));
    chk("almost_full", 32'(almost_full_o), 32'(mdl.size() >= AfTh));
`ifdef QUEUE_ERR_FLAGS_EN
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
    chk("underflow", 32'(underflow_o), 32'(unf_m));
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input logic we, input logic [7:0] d, input logic re);
    bit push_ok, pop_ok;
    push_ok = we && (mdl.size() < Depth);
    pop_ok  = re && (mdl.size() > 0);
    if (we && !push_ok) ovf_m = 1'b1;
    if (re && !pop_ok) unf_m = 1'b1;
    Wr_en_i = we;
    data_i  = d;
    Rd_en_i = re;
    if (pop_ok) sb.push_back(mdl.pop_front());
    if (push_ok) mdl.push_back(d);
    @(posedge Clk_i);
    @(negedge Clk_i);
    Wr_en_i = 1'b0;
    Rd_en_i = 1'b0;
    chk("rd_valid", 32'(Rd_valid_o), 32'(pop_ok));
    if (pop_ok) last_data = sb.pop_front();
    chk("data", 32'(data_o), 32'(last_data));
    check_state();
  endtask

  task automatic do_reset(input int cycles, input logic we, input logic re);
    Rst_i   = 1'b0;
    Wr_en_i = we;
    Rd_en_i = re;
    data_i  = 8'hEE;
    repeat (cycles) begin
      @(posedge Clk_i);
      @(negedge Clk_i);
    end
    Rst_i   = 1'b1;
    Wr_en_i = 1'b0;
    Rd_en_i = 1'b0;
    mdl.delete();
    sb.delete();
    last_data = 8'h00;
    ovf_m     = 1'b0;
    unf_m     = 1'b0;
    chk("reset_rd_valid", 32'(Rd_valid_o), 32'd0);
    chk("reset_data", 32'(data_o), 32'd0);
    check_state();
  endtask

  initial begin
    Rst_i     = 1'b0;
    Wr_en_i   = 1'b0;
    Rd_en_i   = 1'b0;
    data_i    = 8'h00;
    last_data = 8'h00;
    ovf_m     = 1'b0;
    unf_m     = 1'b0;
    @(negedge Clk_i);

    do_reset(2, 1'b0, 1'b0);

    // Fill and drain in order.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // Full with push+pop: push dropped, oldest popped.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);

    // Empty with push+pop: only the push lands.
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Steady state at count 8 across pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

    // Rejected requests, then reset mid-stream.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h77, 1'b1);
    do_reset(1, 1'b1, 1'b1);

    step(1'b1, 8'h42, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
